// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets fetch (IF) and memory stage (MEM) share a single-port RAM.
// Each RAM transaction lasts LAT cycles. MEM wins over IF. A requester that was just
// served skips the arbitration in its own pulse cycle, so the two requesters alternate.
//
// Ports:
//   CLK, RST                      clock (rising edge), asynchronous active-low reset
//   IF_REQ/IF_ADDR                fetch read request and address
//   IF_GNT/IF_DATA                one-cycle grant pulse, last fetched word
//   MEM_REQ/WE/SIZE/ADDR/WDATA    data access request
//   MEM_DONE/MEM_RDATA            one-cycle completion pulse, last load data
//   RAM_*                         single-port RAM interface (RAM_RDATA valid in last cycle)
//   STALL_IF, STALL_ALL           pipeline hold controls
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic [DATA_W-1:0] IF_DATA,
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [1:0]        MEM_SIZE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_DONE,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [1:0]        RAM_SIZE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              STALL_IF,
  output logic              STALL_ALL
);

  localparam int unsigned     CntW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LAT - 1);

  typedef enum logic {StIdle, StAcc} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                owner_mem_q, owner_mem_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                if_gnt_q, if_gnt_d;
  logic                mem_done_q, mem_done_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                mem_elig, if_elig, acc, last;

  // A requester whose pulse is high this cycle has just been served and yields.
  assign mem_elig = MEM_REQ && !mem_done_q;
  assign if_elig  = IF_REQ && !if_gnt_q;
  assign acc      = (state_q == StAcc);
  assign last     = acc && (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_gnt_d    = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (mem_elig) begin
          owner_mem_d = 1'b1;
          we_d        = MEM_WE;
          size_d      = MEM_SIZE;
          addr_d      = MEM_ADDR;
          wdata_d     = MEM_WDATA;
          cnt_d       = CntInit;
          state_d     = StAcc;
        end else if (if_elig) begin
          owner_mem_d = 1'b0;
          we_d        = 1'b0;
          size_d      = 2'b10;
          addr_d      = IF_ADDR;
          wdata_d     = '0;
          cnt_d       = CntInit;
          state_d     = StAcc;
        end
      end
      StAcc: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
          if (owner_mem_q) begin
            mem_done_d = 1'b1;
            if (!we_q) mem_rdata_d = RAM_RDATA;
          end else begin
            if_gnt_d  = 1'b1;
            if_data_d = RAM_RDATA;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_gnt_q    <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_gnt_q    <= if_gnt_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // RAM bus is zero outside an access; the write strobe only fires in the final cycle,
  // so a reset part-way through a store never reaches the array.
  assign RAM_EN    = acc;
  assign RAM_WE    = last && we_q;
  assign RAM_SIZE  = acc ? size_q : '0;
  assign RAM_ADDR  = acc ? addr_q : '0;
  assign RAM_WDATA = acc ? wdata_q : '0;

  assign IF_GNT    = if_gnt_q;
  assign IF_DATA   = if_data_q;
  assign MEM_DONE  = mem_done_q;
  assign MEM_RDATA = mem_rdata_q;

  // Gated by RST so every output reads 0 while reset is held.
  assign STALL_ALL = RST && MEM_REQ && !mem_done_q;
  assign STALL_IF  = STALL_ALL || (RST && IF_REQ && !if_gnt_q);

endmodule
